// File: rtl/histeq_pkg.sv
// Shared types and constants for the histogram-equalization frame controller.
// Contents: controller state enum, default frame size, LUT word width and
// the maximum equalized output level.
package histeq_pkg;

    localparam int unsigned FramePixelsDef = 640 * 480;
    localparam int unsigned LutWidth       = 8;
    localparam int unsigned MaxLevel       = 255;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCUM,
        S_REQ,
        S_WAIT,
        S_DIV,
        S_WRITE,
        S_DONE
    } state_e;

endpackage

// File: rtl/histeq_div.sv
// Restoring divider producing an 8-bit floor quotient in LutWidth iterations.
// The caller guarantees i_num < 256 * i_den, so only the top 8 quotient bits exist.
// Ports:
//   i_clk, i_reset      clock, async active-high reset
//   i_start             one-cycle start; operands sampled on this edge
//   i_num, i_den        numerator / denominator
//   o_done              one-cycle pulse, LutWidth cycles after start
//   o_quot              quotient, valid while o_done is high
module histeq_div
    import histeq_pkg::*;
#(
    parameter int unsigned NumWidth = 27,
    parameter int unsigned DenWidth = 19
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NumWidth-1:0] i_num,
    input  logic [DenWidth-1:0] i_den,
    output logic                o_done,
    output logic [LutWidth-1:0] o_quot
);

    localparam int unsigned IterWidth = $clog2(LutWidth);

    logic [NumWidth-1:0]  rem_q;
    logic [NumWidth-1:0]  dsh_q;
    logic [NumWidth-1:0]  den_top_c;
    logic [LutWidth-1:0]  quot_q;
    logic [IterWidth-1:0] iter_q;
    logic                 busy_q;
    logic                 first_ge_c;
    logic                 step_ge_c;

    // The first (MSB) iteration is folded into the start edge so done lands LutWidth cycles later.
    assign den_top_c  = NumWidth'(i_den) << (LutWidth - 1);
    assign first_ge_c = i_num >= den_top_c;
    assign step_ge_c  = rem_q >= dsh_q;
    assign o_quot     = quot_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quot_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                rem_q  <= first_ge_c ? i_num - den_top_c : i_num;
                quot_q <= LutWidth'(first_ge_c);
                dsh_q  <= den_top_c >> 1;
                iter_q <= IterWidth'(LutWidth - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= step_ge_c ? rem_q - dsh_q : rem_q;
                quot_q <= {quot_q[LutWidth-2:0], step_ge_c};
                dsh_q  <= dsh_q >> 1;
                iter_q <= iter_q - IterWidth'(1);
                if (iter_q == IterWidth'(1)) begin
                    busy_q <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/histeq_ctrl.sv
// Frame sequencer for histogram equalization: gates one frame of pixels into
// the threshold-counter bank, scans the bank bin by bin, computes each
// equalized level, writes it to the inactive LUT bank, then clears the bank.
// Ports:
//   i_clk, i_reset                 clock, async active-high reset
//   i_enable                       permits a new frame to start
//   i_pixel_valid / o_pixel_ready  upstream pixel handshake
//   o_cdf_pixel_valid              accepted-pixel strobe to the counter bank
//   o_cdf_reset_n                  one-cycle synchronous clear to the counter bank
//   o_bin_sel / i_cdf_value        bank read-mux select and registered result
//   o_lut_we/addr/data             LUT write port
//   o_lut_bank                     bank currently read by the mapper
//   o_frame_done / o_cdf_error     end-of-build pulse and total-count check
module histeq_ctrl
    import histeq_pkg::*;
#(
    parameter int unsigned DataWidth   = 8,
    parameter int unsigned FramePixels = FramePixelsDef,
    parameter int unsigned CountWidth  = $clog2(640 * 480)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_pixel_valid,
    output logic                  o_pixel_ready,
    output logic                  o_cdf_pixel_valid,
    output logic                  o_cdf_reset_n,
    output logic [DataWidth-1:0]  o_bin_sel,
    input  logic [CountWidth-1:0] i_cdf_value,
    output logic                  o_lut_we,
    output logic [DataWidth-1:0]  o_lut_addr,
    output logic [LutWidth-1:0]   o_lut_data,
    output logic                  o_lut_bank,
    output logic                  o_frame_done,
    output logic                  o_cdf_error
);

    localparam int unsigned            NumWidth   = CountWidth + LutWidth;
    localparam logic [DataWidth-1:0]   MaxBin     = '1;
    localparam logic [CountWidth-1:0]  FrameCount = CountWidth'(FramePixels);
    localparam logic [CountWidth-1:0]  LastPixel  = CountWidth'(FramePixels - 1);

    state_e                state_q, state_next;
    logic [CountWidth-1:0] pix_cnt_q;
    logic [DataWidth-1:0]  bin_q;
    logic [CountWidth-1:0] cdf_q;
    logic [CountWidth-1:0] cdf_min_q;
    logic                  min_valid_q;
    logic [LutWidth-1:0]   lut_q;

    logic                  pixel_ready_q, lut_we_q, frame_done_q, cdf_error_q;
    logic                  cdf_reset_n_q, bank_q;
    logic                  pixel_ready_d, lut_we_d, frame_done_d, cdf_error_d;
    logic                  cdf_reset_n_d;

    logic                  accept_c, last_pixel_c, zero_bin_c, den_zero_c, div_start_c;
    logic [CountWidth-1:0] min_sel_c, den_c;
    logic [NumWidth-1:0]   num_c;
    logic                  div_done;
    logic [LutWidth-1:0]   div_quot;

    assign accept_c     = i_pixel_valid & pixel_ready_q;
    assign last_pixel_c = pix_cnt_q == LastPixel;

    // Bin decision in WAIT: the first nonzero cdf becomes cdf_min on the fly.
    assign min_sel_c   = min_valid_q ? cdf_min_q : i_cdf_value;
    assign zero_bin_c  = !min_valid_q && (i_cdf_value == '0);
    assign den_c       = FrameCount - min_sel_c;
    assign den_zero_c  = den_c == '0;
    assign num_c       = NumWidth'(i_cdf_value - min_sel_c) * NumWidth'(MaxLevel);
    assign div_start_c = (state_q == S_WAIT) && !zero_bin_c && !den_zero_c;

    histeq_div #(
        .NumWidth (NumWidth),
        .DenWidth (CountWidth)
    ) u_div (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (div_start_c),
        .i_num   (num_c),
        .i_den   (den_c),
        .o_done  (div_done),
        .o_quot  (div_quot)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= S_CLEAR;
        else         state_q <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_CLEAR: state_next = S_IDLE;
            S_IDLE:  if (i_enable) state_next = S_ACCUM;
            S_ACCUM: if (accept_c && last_pixel_c) state_next = S_REQ;
            S_REQ:   state_next = S_WAIT;
            S_WAIT:  state_next = (zero_bin_c || den_zero_c) ? S_WRITE : S_DIV;
            S_DIV:   if (div_done) state_next = S_WRITE;
            S_WRITE: state_next = (bin_q == MaxBin) ? S_DONE : S_REQ;
            S_DONE:  state_next = S_CLEAR;
            default: state_next = S_CLEAR;
        endcase
    end

    // Output decode; strobes follow the upcoming state so their registers align with it.
    always_comb begin
        pixel_ready_d = state_next == S_ACCUM;
        lut_we_d      = state_next == S_WRITE;
        frame_done_d  = state_next == S_DONE;
        cdf_error_d   = (state_next == S_DONE) && (cdf_q != FrameCount);
        cdf_reset_n_d = state_q != S_CLEAR;
    end

    // Output registers; the counter clear lands in the cycle after CLEAR.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pixel_ready_q <= 1'b0;
            lut_we_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            cdf_error_q   <= 1'b0;
            cdf_reset_n_q <= 1'b1;
            bank_q        <= 1'b0;
        end else begin
            pixel_ready_q <= pixel_ready_d;
            lut_we_q      <= lut_we_d;
            frame_done_q  <= frame_done_d;
            cdf_error_q   <= cdf_error_d;
            cdf_reset_n_q <= cdf_reset_n_d;
            bank_q        <= bank_q ^ frame_done_d;
        end
    end

    // Pixel counter, bin index, cdf_min and equalized level
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pix_cnt_q   <= '0;
            bin_q       <= '0;
            cdf_q       <= '0;
            cdf_min_q   <= '0;
            min_valid_q <= 1'b0;
            lut_q       <= '0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept_c) begin
                        if (last_pixel_c) begin
                            pix_cnt_q <= '0;
                            bin_q     <= '0;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + CountWidth'(1);
                        end
                    end
                end
                S_WAIT: begin
                    cdf_q <= i_cdf_value;
                    if (zero_bin_c) begin
                        lut_q <= '0;
                    end else begin
                        if (!min_valid_q) begin
                            cdf_min_q   <= i_cdf_value;
                            min_valid_q <= 1'b1;
                        end
                        if (den_zero_c) lut_q <= LutWidth'(bin_q);
                    end
                end
                S_DIV:   if (div_done) lut_q <= div_quot;
                S_WRITE: if (bin_q != MaxBin) bin_q <= bin_q + DataWidth'(1);
                S_DONE: begin
                    cdf_min_q   <= '0;
                    min_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_pixel_ready     = pixel_ready_q;
    assign o_cdf_pixel_valid = i_pixel_valid & pixel_ready_q;
    assign o_cdf_reset_n     = cdf_reset_n_q;
    assign o_bin_sel         = bin_q;
    assign o_lut_we          = lut_we_q;
    assign o_lut_addr        = bin_q;
    assign o_lut_data        = lut_q;
    assign o_lut_bank        = bank_q;
    assign o_frame_done      = frame_done_q;
    assign o_cdf_error       = cdf_error_q;

endmodule

// File: tb/tb_histeq_ctrl.sv
// Scoreboard bench for histeq_ctrl with a threshold-counter bank model and
// a histogram/CDF reference model of the equalized LUT.
module tb_histeq_ctrl;

    localparam int unsigned FP = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned CW = $clog2(640 * 480);
    localparam int unsigned NB = 256;

    logic          i_clk;
    logic          i_reset;
    logic          i_enable;
    logic          i_pixel_valid;
    logic          o_pixel_ready;
    logic          o_cdf_pixel_valid;
    logic          o_cdf_reset_n;
    logic [DW-1:0] o_bin_sel;
    logic [CW-1:0] i_cdf_value;
    logic          o_lut_we;
    logic [DW-1:0] o_lut_addr;
    logic [7:0]    o_lut_data;
    logic          o_lut_bank;
    logic          o_frame_done;
    logic          o_cdf_error;

    histeq_ctrl #(
        .DataWidth   (DW),
        .FramePixels (FP)
    ) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_pixel_valid     (i_pixel_valid),
        .o_pixel_ready     (o_pixel_ready),
        .o_cdf_pixel_valid (o_cdf_pixel_valid),
        .o_cdf_reset_n     (o_cdf_reset_n),
        .o_bin_sel         (o_bin_sel),
        .i_cdf_value       (i_cdf_value),
        .o_lut_we          (o_lut_we),
        .o_lut_addr        (o_lut_addr),
        .o_lut_data        (o_lut_data),
        .o_lut_bank        (o_lut_bank),
        .o_frame_done      (o_frame_done),
        .o_cdf_error       (o_cdf_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed { logic [7:0] addr; logic [7:0] data; } lut_exp_t;
    typedef struct packed { logic err; logic bank; } frm_exp_t;

    lut_exp_t    lut_q[$];
    frm_exp_t    frm_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          exp_bank = 1'b0;
    bit          bank_pend = 1'b0;
    bit          bank_pend_val = 1'b0;
    bit          force_err = 1'b0;
    int unsigned pix[FP];
    logic [7:0]  pix_cur = 8'd0;
    int unsigned bank_cnt[NB];

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Counter bank: counter b counts accepted pixels <= b; read mux registered.
    always @(posedge i_clk) begin
        if (!o_cdf_reset_n) begin
            for (int b = 0; b < NB; b++) bank_cnt[b] <= 0;
        end else if (o_cdf_pixel_valid) begin
            for (int b = 0; b < NB; b++)
                if (int'(pix_cur) <= b) bank_cnt[b] <= bank_cnt[b] + 1;
        end
        i_cdf_value <= (force_err && o_bin_sel == 8'd255) ? CW'(15) : CW'(bank_cnt[o_bin_sel]);
    end

    // Reference: histogram -> running CDF -> equalized level per bin.
    task automatic build_expect(input bit ferr);
        int unsigned hist[NB];
        int unsigned cdf[NB];
        int unsigned run = 0;
        int unsigned mn = 0;
        int unsigned den;
        bit found = 1'b0;
        lut_exp_t e;
        frm_exp_t f;
        for (int b = 0; b < NB; b++) hist[b] = 0;
        for (int i = 0; i < FP; i++) hist[pix[i]]++;
        for (int b = 0; b < NB; b++) begin
            run += hist[b];
            cdf[b] = run;
        end
        if (ferr) cdf[NB-1] = 15;
        for (int b = 0; b < NB; b++)
            if (!found && cdf[b] != 0) begin
                mn = cdf[b];
                found = 1'b1;
            end
        den = FP - mn;
        for (int b = 0; b < NB; b++) begin
            e.addr = 8'(b);
            if (cdf[b] == 0)   e.data = 8'd0;
            else if (den == 0) e.data = 8'(b);
            else               e.data = 8'(((cdf[b] - mn) * 255) / den);
            lut_q.push_back(e);
        end
        exp_bank = ~exp_bank;
        f.err  = (cdf[NB-1] != FP);
        f.bank = exp_bank;
        frm_q.push_back(f);
    endtask

    task automatic fill_pixels(input int mode);
        int unsigned j, t;
        for (int i = 0; i < FP; i++) begin
            case (mode)
                0:       pix[i] = 5;
                1:       pix[i] = (i < FP / 2) ? 0 : 255;
                2:       pix[i] = $urandom_range(0, 255);
                default: pix[i] = $urandom_range(100, 110);
            endcase
        end
        for (int i = FP - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = pix[i];
            pix[i] = pix[j];
            pix[j] = t;
        end
    endtask

    // vmode: 0 valid always, 1 valid every other cycle, 2 random valid
    task automatic drive_frame(input int vmode, input bit drop_en, input bit ferr);
        int acc = 0;
        int cyc = 0;
        int extra = 0;
        force_err = ferr;
        i_enable  = 1'b1;
        while (acc < int'(FP) && cyc < 400) begin
            @(negedge i_clk);
            case (vmode)
                0:       i_pixel_valid = 1'b1;
                1:       i_pixel_valid = (cyc % 2) == 0;
                default: i_pixel_valid = 1'($urandom_range(0, 1));
            endcase
            pix_cur = 8'(pix[acc]);
            #1;
            if (o_cdf_pixel_valid) begin
                acc++;
                if (drop_en && acc == 5) i_enable = 1'b0;
            end
            cyc++;
        end
        chk("frame_fill", acc, FP);
        if (acc == int'(FP)) build_expect(ferr);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            i_pixel_valid = 1'b1;
            #1;
            if (k == 0) chk("ready_drop", o_pixel_ready, 0);
            if (o_cdf_pixel_valid) extra++;
        end
        i_pixel_valid = 1'b0;
        chk("accept_count", acc + extra, FP);
    endtask

    task automatic wait_frame();
        int cyc = 0;
        while ((frm_q.size() != 0 || bank_pend) && cyc < 4000) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("frame_timeout", int'(cyc < 4000), 1);
        chk("lut_writes_left", lut_q.size(), 0);
        force_err = 1'b0;
    endtask

    task automatic count_clear_pulse(input string name);
        int lows = 0;
        repeat (5) begin
            @(negedge i_clk);
            if (!o_cdf_reset_n) lows++;
        end
        chk(name, lows, 1);
    endtask

    // Monitor / scoreboard checker
    always @(negedge i_clk) begin
        lut_exp_t e;
        frm_exp_t f;
        if (bank_pend) begin
            chk("lut_bank", o_lut_bank, bank_pend_val);
            bank_pend = 1'b0;
        end
        if (o_lut_we) begin
            chk("we_during_accum", o_pixel_ready, 0);
            if (lut_q.size() == 0) begin
                chk("unexpected_lut_write", 1, 0);
            end else begin
                e = lut_q.pop_front();
                chk("lut_addr", o_lut_addr, e.addr);
                chk($sformatf("lut_data[%0d]", e.addr), o_lut_data, e.data);
            end
        end
        if (o_frame_done) begin
            if (frm_q.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                f = frm_q.pop_front();
                chk("cdf_error", o_cdf_error, f.err);
                bank_pend     = 1'b1;
                bank_pend_val = f.bank;
            end
        end else if (o_cdf_error) begin
            chk("stray_cdf_error", 1, 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        i_reset       = 1'b1;
        i_enable      = 1'b0;
        i_pixel_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_pixel_ready", o_pixel_ready, 0);
        chk("rst_lut_we", o_lut_we, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_cdf_error", o_cdf_error, 0);
        chk("rst_lut_bank", o_lut_bank, 0);
        chk("rst_bin_sel", o_bin_sel, 0);
        chk("rst_lut_addr", o_lut_addr, 0);
        chk("rst_lut_data", o_lut_data, 0);
        chk("rst_cdf_reset_n", o_cdf_reset_n, 1);
        i_reset = 1'b0;
        count_clear_pulse("clear_after_reset");

        fill_pixels(0); drive_frame(0, 1'b0, 1'b0); wait_frame();  // all pixels 5
        fill_pixels(1); drive_frame(1, 1'b0, 1'b0); wait_frame();  // 0 / 255 split
        fill_pixels(2); drive_frame(2, 1'b0, 1'b1); wait_frame();  // cdf[255] reads 15
        fill_pixels(3); drive_frame(0, 1'b1, 1'b0); wait_frame();  // enable drops mid-frame
        fill_pixels(2); drive_frame(2, 1'b0, 1'b0); wait_frame();  // leaves bank at 1

        // Abort the scan with reset once bin 100 is written.
        fill_pixels(2); drive_frame(2, 1'b0, 1'b0);
        cyc = 0;
        do begin
            @(negedge i_clk);
            cyc++;
        end while (!(o_lut_we && o_lut_addr == 8'd100) && cyc < 3000);
        chk("reached_bin100", int'(cyc < 3000), 1);
        #2;
        i_reset = 1'b1;
        #1;
        lut_q.delete();
        frm_q.delete();
        bank_pend = 1'b0;
        exp_bank  = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("abort_lut_bank", o_lut_bank, 0);
            chk("abort_lut_we", o_lut_we, 0);
            chk("abort_cdf_reset_n", o_cdf_reset_n, 1);
        end
        i_reset = 1'b0;
        count_clear_pulse("clear_after_abort");
        repeat (20) @(negedge i_clk);

        fill_pixels(2); drive_frame(2, 1'b0, 1'b0); wait_frame();  // recovery frame

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
